// File: rtl/pc_pkg.sv
// Core-wide fetch/address constants shared by fetch, decode and the branch unit.
package pc_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned INST_BYTES   = 4;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t       RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc.sv
// Fetch-stage program counter: word-aligned register that either steps by INC
// or loads a redirect target; async active-low reset to RESET_VECTOR.
module pc #(
  parameter int unsigned       XLEN         = pc_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(pc_pkg::RESET_VECTOR),
  parameter int unsigned       INC          = pc_pkg::INST_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_jmp,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            jmp_misaligned
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_seq;

  // Single adder feeds both the sequential next-PC and the link value.
  assign pc_seq   = pc_q + XLEN'(INC);
  assign pc_plus4 = pc_seq;
  assign pc_out   = pc_q;

  assign jmp_misaligned = pc_jmp & (pc_in[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else if (pc_jmp) begin
      pc_q <= {pc_in[XLEN-1:2], 2'b00};
    end else begin
      pc_q <= pc_seq;
    end
  end

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: stimulus queues the expected PC for each cycle,
// a monitor pops and compares at the falling edge or on an async-reset probe.
module tb_pc;

  logic        clk;
  logic        rst;
  logic        pc_jmp;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        jmp_misaligned;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    string       name;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  event probe;

  pc #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .INC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_jmp(pc_jmp),
    .pc_in(pc_in),
    .pc_out(pc_out),
    .pc_plus4(pc_plus4),
    .jmp_misaligned(jmp_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  // Monitor: compare every queued expectation when it comes due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or probe);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (pc_out !== e.pc) begin
          bad++;
          $display("FAIL %s pc_out: got %h want %h", e.name, pc_out, e.pc);
        end
        total++;
        if (pc_plus4 !== e.pc + 32'd4) begin
          bad++;
          $display("FAIL %s pc_plus4: got %h want %h", e.name, pc_plus4, e.pc + 32'd4);
        end
        total++;
        if (jmp_misaligned !== e.mis) begin
          bad++;
          $display("FAIL %s jmp_misaligned: got %b want %b", e.name, jmp_misaligned, e.mis);
        end
      end
    end
  end

  // Drive inputs for the next edge and queue what pc_out shows during this cycle.
  task automatic cyc(input logic r, input logic j, input logic [31:0] in,
                     input logic [31:0] exp_pc, input logic exp_mis, input string nm);
    rst    = r;
    pc_jmp = j;
    pc_in  = in;
    sb.push_back('{exp_pc, exp_mis, nm});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b0;
    pc_jmp = 1'b0;
    pc_in  = 32'h0;

    #2;
    sb.push_back('{32'h0, 1'b0, "rst_pre_edge"});
    ->probe;
    @(posedge clk);
    #1;

    cyc(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, "rst_hold0");
    cyc(1'b0, 1'b1, 32'h0000_0700, 32'h0000_0000, 1'b0, "rst_hold_jmp");
    cyc(1'b1, 1'b0, 'x,            32'h0000_0000, 1'b0, "release");
    cyc(1'b1, 1'b0, 'x,            32'h0000_0004, 1'b0, "seq_4");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0, "seq_8");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_000C, 1'b0, "seq_c");
    cyc(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0010, 1'b0, "seq_10");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_1000, 1'b0, "jmp_1000");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_1004, 1'b0, "jmp_1004");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_1008, 1'b0, "jmp_1008");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_100C, 1'b0, "jmp_100c");
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_1010, 1'b0, "jmp_1010");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, "wrap_top");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, "wrap_zero");
    cyc(1'b1, 1'b1, 32'h0000_2003, 32'h0000_0004, 1'b1, "mis_pre");
    cyc(1'b1, 1'b0, 32'h0000_2003, 32'h0000_2000, 1'b0, "mis_load");
    cyc(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2004, 1'b0, "mis_next");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_1000, 1'b0, "run_1000");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_1004, 1'b0, "run_1004");

    // Redirect to 0x500 is set up, then reset hits between edges.
    rst    = 1'b1;
    pc_jmp = 1'b1;
    pc_in  = 32'h0000_0500;
    sb.push_back('{32'h0000_1008, 1'b0, "pre_arst"});
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    sb.push_back('{32'h0000_0000, 1'b0, "arst_immediate"});
    ->probe;
    @(posedge clk);
    #1;

    cyc(1'b0, 1'b1, 32'h0000_0500, 32'h0000_0000, 1'b0, "arst_hold");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, "arst_release");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, "restart_4");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0, "restart_8");

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc.md
Name: pc

Overview:
- Program counter register for the single-issue RV32I core's fetch stage.
- Holds the current instruction address and presents it on pc_out to instruction memory and the branch/jump logic.
- Every clock it either advances to the next sequential word (PC+4) or loads a redirect target supplied by the execute stage.

Parameters:
- XLEN, 32, address/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded on reset.
- INC, 4, sequential increment in bytes; one 32-bit instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_jmp  input  1  redirect strobe; 1 = load pc_in at the next rising edge.
- pc_in  input  XLEN  redirect target address (branch/JAL/JALR result).
- pc_out  output  XLEN  current PC, driven directly from the register; no combinational path from inputs.
- pc_plus4  output  XLEN  combinational pc_out + INC, modulo 2^XLEN; for link-register writeback.
- jmp_misaligned  output  1  combinational; 1 when pc_jmp=1 and pc_in[1:0] != 0.

Behaviour:
- Reset: rst=0 forces pc_out = RESET_VECTOR immediately, without waiting for a clock edge. The register holds that value while rst=0 regardless of clk, pc_jmp or pc_in.
- Reset release: rst going 0->1 takes effect with no extra delay. The first rising edge with rst=1 updates the PC.
- Each rising edge with rst=1:
  - pc_jmp=1: pc_out <= {pc_in[XLEN-1:2], 2'b00}. The two LSBs are cleared so the PC is always word-aligned.
  - pc_jmp=0: pc_out <= pc_out + INC.
- Latency: a redirect is visible on pc_out one cycle after the edge that samples pc_jmp=1. Sequential increments continue from the loaded value on the following edges.
- Wrap-around: addition is unsigned modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- pc_jmp held high for several cycles: pc_in is reloaded on every edge, so the PC stays on pc_in if pc_in is constant.
- Simultaneous reset and pc_jmp: reset wins.
- Reset asserted mid-run: pc_out returns to RESET_VECTOR asynchronously. Any pending redirect is discarded.
- jmp_misaligned:
  - Informational only; the load still occurs with the LSBs cleared.
  - It is 0 whenever pc_jmp=0 and is not registered.
  - The trap unit consumes it in the same cycle.
- Inputs are sampled only at rising edges. X on pc_in while pc_jmp=0 must not affect pc_out.
- pc_out is never X after reset has been applied once.

Decomposition:
- Shared package (core-wide): XLEN=32, RESET_VECTOR, INST_BYTES=4, and an addr_t typedef of XLEN bits. Fetch, decode and the branch unit use the same constants.
- No sub-module. The block is one register plus an adder and a mux.
- Keep the +INC adder inline. It is shared with the pc_plus4 output, not duplicated.

Test Plan:
- Reset hold: drive rst=0 for 2 cycles with pc_jmp=0 -> pc_out = 0x0000_0000 throughout, including between edges.
- Sequential run: release rst, 4 edges with pc_jmp=0 -> pc_out = 0x4, 0x8, 0xC, 0x10. pc_plus4 is always pc_out+4.
- Jump: pc_in=0x0000_1000, pc_jmp=1 for one edge, then 0 for 4 edges -> pc_out = 0x1000, 0x1004, 0x1008, 0x100C, 0x1010.
- Wrap-around: pc_in=0xFFFF_FFFC, pc_jmp=1 for one edge, then 0 -> pc_out = 0xFFFF_FFFC, then 0x0000_0000, 0x0000_0004.
- Misaligned target: pc_in=0x0000_2003 with pc_jmp=1 -> jmp_misaligned=1 before the edge, pc_out=0x0000_2000 after; jmp_misaligned=0 once pc_jmp=0.
- Async reset mid-run: with pc_out=0x1008, pull rst=0 between clock edges -> pc_out = 0x0 immediately. A same-cycle pc_jmp=1 with pc_in=0x500 is ignored. After release, the sequence restarts 0x4, 0x8.
